// File: rtl/upstream_order_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : upstream_order_sequencer
// Purpose  : Queues incoming orders and sequences risk check, memory write and
//            risk-maximum updates through a one-hot control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module upstream_order_sequencer #(
  parameter int ID_W         = 8,
  parameter int DEPTH        = 4,
  parameter int RISK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     HRESET,
  input  logic                     new_order,
  input  logic [ID_W-1:0]          order_id,
  input  logic                     new_max,
  input  logic                     risk_ok,
  input  logic                     risk_fail,
  input  logic                     memwr,
  output logic                     check_risk,
  output logic [ID_W-1:0]          risk_id,
  output logic                     send_order,
  output logic [ID_W-1:0]          send_id,
  output logic                     update_max,
  output logic                     order_sent,
  output logic                     order_rejected,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(RISK_TIMEOUT + 1);
  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] C_TIMEOUT = TW'(RISK_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE      = 4'b0001,
    S_RISKCHECK = 4'b0010,
    S_SENDORDER = 4'b0100,
    S_NEWMAX    = 4'b1000
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [ID_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [ID_W-1:0] r_cur_id;
  logic            r_max_pend;
  logic [TW-1:0]   r_timer;
  logic            r_order_sent;
  logic            r_order_rejected;
  logic            r_drop;

  logic            w_dispatch;
  logic            w_pop;
  logic            w_push;
  logic            w_sent;
  logic            w_rejected;
  logic            w_enter_max;

  always_comb begin
    w_next_state = r_state;
    w_dispatch   = 1'b0;
    w_sent       = 1'b0;
    w_rejected   = 1'b0;
    w_pop        = 1'b0;
    w_enter_max  = 1'b0;
    case (r_state)
      S_IDLE: w_dispatch = 1'b1;
      S_RISKCHECK: begin
        // A simultaneous ok/fail verdict is treated as a failure.
        if (risk_fail) begin
          w_rejected = 1'b1;
          w_dispatch = 1'b1;
        end else if (risk_ok) begin
          w_next_state = S_SENDORDER;
        end else if (r_timer == C_TIMEOUT) begin
          w_rejected = 1'b1;
          w_dispatch = 1'b1;
        end
      end
      S_SENDORDER: begin
        if (memwr) begin
          w_sent     = 1'b1;
          w_dispatch = 1'b1;
        end
      end
      S_NEWMAX: begin
        if (memwr) w_dispatch = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase

    if (w_dispatch) begin
      if (r_max_pend) begin
        w_next_state = S_NEWMAX;
        w_enter_max  = 1'b1;
      end else if (r_count != '0) begin
        w_next_state = S_RISKCHECK;
        w_pop        = 1'b1;
      end else begin
        w_next_state = S_IDLE;
      end
    end
  end

  // A full FIFO still accepts an order when the head leaves on the same edge.
  assign w_push = new_order && ((r_count != C_DEPTH) || w_pop);

  always_ff @(posedge clk) begin
    if (HRESET) begin
      r_state          <= S_IDLE;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_cur_id         <= '0;
      r_max_pend       <= 1'b0;
      r_timer          <= '0;
      r_order_sent     <= 1'b0;
      r_order_rejected <= 1'b0;
      r_drop           <= 1'b0;
    end else begin
      r_state          <= w_next_state;
      r_order_sent     <= w_sent;
      r_order_rejected <= w_rejected;
      r_drop           <= new_order && !w_push;
      r_max_pend       <= new_max | (r_max_pend & ~w_enter_max);
      r_count          <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_cur_id <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_pop)
        r_timer <= TW'(1);
      else if (r_state == S_RISKCHECK && w_next_state == S_RISKCHECK)
        r_timer <= r_timer + TW'(1);
      else
        r_timer <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!HRESET && w_push) r_mem[r_wr_ptr] <= order_id;
  end

  assign check_risk     = (r_state == S_RISKCHECK);
  assign send_order     = (r_state == S_SENDORDER);
  assign update_max     = (r_state == S_NEWMAX);
  assign risk_id        = check_risk ? r_cur_id : '0;
  assign send_id        = send_order ? r_cur_id : '0;
  assign order_sent     = r_order_sent;
  assign order_rejected = r_order_rejected;
  assign drop           = r_drop;
  assign q_count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_upstream_order_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_upstream_order_sequencer
// Purpose  : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_upstream_order_sequencer;

  localparam int ID_W         = 8;
  localparam int DEPTH        = 4;
  localparam int RISK_TIMEOUT = 15;
  localparam int QW           = $clog2(DEPTH) + 1;
  localparam int OW           = 2*ID_W + QW + 6;
  localparam int PH_IDLE = 0, PH_RISK = 1, PH_SEND = 2, PH_MAX = 3;

  logic            clk = 1'b0;
  logic            HRESET = 1'b0;
  logic            new_order = 1'b0;
  logic [ID_W-1:0] order_id = '0;
  logic            new_max = 1'b0;
  logic            risk_ok = 1'b0;
  logic            risk_fail = 1'b0;
  logic            memwr = 1'b0;
  logic            check_risk, send_order, update_max;
  logic            order_sent, order_rejected, drop;
  logic [ID_W-1:0] risk_id, send_id;
  logic [QW-1:0]   q_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int              m_phase = PH_IDLE;
  logic [ID_W-1:0] m_q[$];
  logic [ID_W-1:0] m_cur = '0;
  bit              m_maxp = 1'b0;
  int              m_age = 0;
  bit              m_sent = 1'b0, m_rej = 1'b0, m_drop = 1'b0;

  upstream_order_sequencer #(
    .ID_W(ID_W), .DEPTH(DEPTH), .RISK_TIMEOUT(RISK_TIMEOUT)
  ) dut (
    .clk(clk), .HRESET(HRESET), .new_order(new_order), .order_id(order_id),
    .new_max(new_max), .risk_ok(risk_ok), .risk_fail(risk_fail), .memwr(memwr),
    .check_risk(check_risk), .risk_id(risk_id), .send_order(send_order),
    .send_id(send_id), .update_max(update_max), .order_sent(order_sent),
    .order_rejected(order_rejected), .drop(drop), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] pack(input logic cr, input logic [ID_W-1:0] rid,
                                         input logic sd, input logic [ID_W-1:0] sid,
                                         input logic um, input logic os, input logic orj,
                                         input logic dr, input int qc);
    return {cr, rid, sd, sid, um, os, orj, dr, QW'(qc)};
  endfunction

  function automatic logic [OW-1:0] dut_outs();
    return {check_risk, risk_id, send_order, send_id, update_max,
            order_sent, order_rejected, drop, q_count};
  endfunction

  function automatic logic [OW-1:0] model_outs();
    return pack(m_phase == PH_RISK, (m_phase == PH_RISK) ? m_cur : '0,
                m_phase == PH_SEND, (m_phase == PH_SEND) ? m_cur : '0,
                m_phase == PH_MAX, m_sent, m_rej, m_drop, m_q.size());
  endfunction

  // One clock edge of the order-sequencing rules, applied to sampled inputs.
  task automatic model_step();
    bit disp, popped, to_max;
    int sz;
    if (HRESET) begin
      m_phase = PH_IDLE; m_q.delete(); m_cur = '0; m_maxp = 0; m_age = 0;
      m_sent = 0; m_rej = 0; m_drop = 0;
      return;
    end
    m_sent = 0; m_rej = 0; m_drop = 0;
    disp = 0; popped = 0; to_max = 0;
    sz = m_q.size();
    case (m_phase)
      PH_IDLE: disp = 1;
      PH_RISK: begin
        if (risk_fail) begin m_rej = 1; disp = 1; end
        else if (risk_ok) m_phase = PH_SEND;
        else if (m_age >= RISK_TIMEOUT) begin m_rej = 1; disp = 1; end
        else m_age++;
      end
      PH_SEND: if (memwr) begin m_sent = 1; disp = 1; end
      default: if (memwr) disp = 1;
    endcase
    if (disp) begin
      if (m_maxp) begin m_phase = PH_MAX; to_max = 1; end
      else if (sz > 0) begin m_cur = m_q.pop_front(); m_age = 1; m_phase = PH_RISK; popped = 1; end
      else m_phase = PH_IDLE;
    end
    m_maxp = new_max || (m_maxp && !to_max);
    if (new_order) begin
      if (sz < DEPTH || popped) m_q.push_back(order_id);
      else m_drop = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    HRESET = 0; new_order = 0; order_id = '0; new_max = 0;
    risk_ok = 0; risk_fail = 0; memwr = 0;
  endtask

  task automatic push_tick(input logic [ID_W-1:0] id);
    new_order = 1; order_id = id;
    tick();
    new_order = 0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] want;
    HRESET = 1; new_order = 1; order_id = 8'h55; new_max = 1; memwr = 1; risk_ok = 1;
    tick(); tick();
    want = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL reset_state: got %h want %h", dut_outs(), want); end
    clear_inputs();
    tick();
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL reset_inputs_ignored: got %h want %h", dut_outs(), want); end
  endtask

  task automatic test_single_order();
    logic [OW-1:0] want;
    push_tick(8'h2A);
    want = pack(0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL single_queued: got %h want %h", dut_outs(), want); end
    tick();
    want = pack(1, 8'h2A, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL single_risk: got %h want %h", dut_outs(), want); end
    tick(); tick();
    risk_ok = 1; tick(); risk_ok = 0;
    want = pack(0, 0, 1, 8'h2A, 0, 0, 0, 0, 0);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL single_send: got %h want %h", dut_outs(), want); end
    tick();
    memwr = 1; tick(); memwr = 0;
    want = pack(0, 0, 0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL single_sent: got %h want %h", dut_outs(), want); end
    tick();
    want = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL single_idle: got %h want %h", dut_outs(), want); end
  endtask

  task automatic test_overflow();
    logic [OW-1:0] want;
    int qc;
    for (int k = 1; k <= 6; k++) begin
      push_tick(ID_W'(k));
      qc = (k == 1) ? 1 : ((k - 1 > DEPTH) ? DEPTH : k - 1);
      want = pack(k >= 2, (k >= 2) ? ID_W'(1) : '0, 0, 0, 0, 0, 0, k == 6, qc);
      n_checks++;
      if (dut_outs() !== want) begin n_errors++; $display("FAIL overflow_fill_%0d: got %h want %h", k, dut_outs(), want); end
    end
    for (int j = 1; j <= 5; j++) begin
      risk_fail = 1; tick(); risk_fail = 0;
      if (j < 5) want = pack(1, ID_W'(j + 1), 0, 0, 0, 0, 1, 0, 4 - j);
      else       want = pack(0, 0, 0, 0, 0, 0, 1, 0, 0);
      n_checks++;
      if (dut_outs() !== want) begin n_errors++; $display("FAIL overflow_order_%0d: got %h want %h", j, dut_outs(), want); end
    end
    tick();
  endtask

  task automatic test_timeout();
    logic [OW-1:0] want;
    push_tick(8'h10);
    push_tick(8'h11);
    want = pack(1, 8'h10, 0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL timeout_enter: got %h want %h", dut_outs(), want); end
    for (int i = 1; i < RISK_TIMEOUT; i++) begin
      tick();
      n_checks++;
      if (dut_outs() !== want) begin n_errors++; $display("FAIL timeout_wait_%0d: got %h want %h", i, dut_outs(), want); end
    end
    tick();
    want = pack(1, 8'h11, 0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL timeout_reject: got %h want %h", dut_outs(), want); end
    risk_fail = 1; tick(); risk_fail = 0;
    tick();
  endtask

  task automatic test_max_priority();
    logic [OW-1:0] want;
    push_tick(8'h21); push_tick(8'h22); push_tick(8'h23);
    risk_ok = 1; tick(); risk_ok = 0;
    new_max = 1; tick(); new_max = 0;
    want = pack(0, 0, 1, 8'h21, 0, 0, 0, 0, 2);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL max_no_abort: got %h want %h", dut_outs(), want); end
    memwr = 1; tick(); memwr = 0;
    want = pack(0, 0, 0, 0, 1, 1, 0, 0, 2);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL max_first: got %h want %h", dut_outs(), want); end
    tick();
    want = pack(0, 0, 0, 0, 1, 0, 0, 0, 2);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL max_hold: got %h want %h", dut_outs(), want); end
    memwr = 1; tick(); memwr = 0;
    want = pack(1, 8'h22, 0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL max_release: got %h want %h", dut_outs(), want); end
    risk_fail = 1; tick(); tick(); risk_fail = 0;
    tick();
  endtask

  task automatic test_conflict();
    logic [OW-1:0] want;
    push_tick(8'h33);
    tick();
    risk_ok = 1; risk_fail = 1; tick(); risk_ok = 0; risk_fail = 0;
    want = pack(0, 0, 0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL conflict_reject: got %h want %h", dut_outs(), want); end
    tick();
    want = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL conflict_no_send: got %h want %h", dut_outs(), want); end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] want;
    push_tick(8'h41); push_tick(8'h42); push_tick(8'h43); push_tick(8'h44);
    risk_ok = 1; tick(); risk_ok = 0;
    want = pack(0, 0, 1, 8'h41, 0, 0, 0, 0, 3);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL rstmid_send: got %h want %h", dut_outs(), want); end
    HRESET = 1; tick(); HRESET = 0;
    want = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL rstmid_cleared: got %h want %h", dut_outs(), want); end
    memwr = 1; tick(); memwr = 0;
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL rstmid_memwr_ignored: got %h want %h", dut_outs(), want); end
    tick();
    n_checks++;
    if (dut_outs() !== want) begin n_errors++; $display("FAIL rstmid_idle: got %h want %h", dut_outs(), want); end
  endtask

  task automatic test_random();
    logic [OW-1:0] want;
    HRESET = 1; tick(); HRESET = 0;
    for (int c = 0; c < 3000; c++) begin
      HRESET    = ($urandom_range(0, 199) == 0);
      new_order = ($urandom_range(0, 9) < 4);
      order_id  = ID_W'($urandom);
      new_max   = ($urandom_range(0, 29) == 0);
      risk_ok   = ($urandom_range(0, 7) == 0);
      risk_fail = ($urandom_range(0, 15) == 0);
      memwr     = ($urandom_range(0, 3) == 0);
      tick();
      want = model_outs();
      n_checks++;
      if (dut_outs() !== want) begin n_errors++; $display("FAIL random_cycle_%0d: got %h want %h", c, dut_outs(), want); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_order();
    test_overflow();
    test_timeout();
    test_max_priority();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
